input_port_ctrl: RTL and testbench
==================================

INPUT_PORT_CTRL -- requirements
Module: input_port_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, flit width in bits.
REQ-002 SHALL have parameter COORD_WIDTH, default 2, width of each X/Y coordinate.
REQ-003 SHALL have parameters LOCAL_X, LOCAL_Y, default 0, this router's coordinates.
REQ-004 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port fifo_empty  input  1  input-buffer empty flag.
REQ-007 SHALL have port fifo_rd_en  output  1  input-buffer pop; buffer dout valid one cycle later.
REQ-008 SHALL have port fifo_dout  input  DATA_WIDTH  registered input-buffer read data.
REQ-009 SHALL have port req  output  5  one-hot switch-allocation request (0 LOCAL, 1 NORTH, 2 EAST, 3 SOUTH, 4 WEST).
REQ-010 SHALL have port grant  input  1  allocator grant for the current req.
REQ-011 SHALL have port out_valid  output  1  flit presented to crossbar.
REQ-012 SHALL have port out_ready  input  1  crossbar/downstream accepts flit.
REQ-013 SHALL have port out_data  output  DATA_WIDTH  flit presented.

Function
REQ-014 SHALL decode flit type from bits [DATA_WIDTH-1:DATA_WIDTH-2]: 01 HEAD, 00 BODY, 10 TAIL, 11 SINGLE (head+tail).
REQ-015 SHALL take dest X from the COORD_WIDTH bits directly below the type field, dest Y from the next COORD_WIDTH bits.
REQ-016 SHALL implement states IDLE, LOAD, ARB, SEND, WAIT.
REQ-017 IDLE: fifo_rd_en = ~fifo_empty; on pop -> LOAD.
REQ-018 LOAD: capture fifo_dout into flit register; from IDLE path -> compute route, latch req, -> ARB; from WAIT/SEND path -> SEND.
REQ-019 Route, XY order: destX>LOCAL_X EAST, destX<LOCAL_X WEST, else destY>LOCAL_Y NORTH, destY<LOCAL_Y SOUTH, else LOCAL; unsigned compare.
REQ-020 ARB: req held; grant -> SEND next cycle.
REQ-021 SEND: out_valid=1, out_data=flit register; no change until out_ready.
REQ-022 On out_ready in SEND with TAIL/SINGLE flit: req cleared, -> IDLE.
REQ-023 On out_ready with HEAD/BODY flit: if ~fifo_empty assert fifo_rd_en same cycle and -> LOAD, else -> WAIT.
REQ-024 WAIT: req held; fifo_rd_en = ~fifo_empty; on pop -> LOAD.
REQ-025 req SHALL remain stable and one-hot from ARB entry until tail accepted; zero otherwise.
REQ-026 fifo_rd_en SHALL never assert while fifo_empty=1 and at most once per flit.
REQ-027 Minimum head latency: pop in cycle N, req in N+2, out_valid in N+3 with grant in N+2.

Reset
REQ-028 rst SHALL force IDLE, req=0, out_valid=0, fifo_rd_en=0, out_data=0, flit register=0.
REQ-029 rst mid-packet SHALL abandon the packet; remaining flits in the buffer are not flushed by this block.

Configuration
REQ-030 Macro INPUT_PORT_CHECK_EN SHALL, when defined, add output err (1 bit) and drop a BODY/TAIL flit loaded from IDLE, or a HEAD/SINGLE flit loaded mid-packet, pulsing err for one cycle and returning to IDLE (mid-packet: req cleared).
REQ-031 Without INPUT_PORT_CHECK_EN, no err port; a flit loaded from IDLE SHALL be treated as head regardless of type, mid-packet flits forwarded by type field only for tail detection.

Structure
REQ-032 Package noc_pkg SHALL hold flit-type constants, port-index constants, state encoding.
REQ-033 Route computation SHALL be a combinational sub-module xy_route_compute (coords in, one-hot req out).

Verification
REQ-034 LOCAL=(1,1), HEAD dest (3,1), BODY, TAIL, grant immediate, out_ready=1 -> req=00100 (EAST), three flits out in order, req=0 after tail.
REQ-035 SINGLE dest (1,1) -> req=00001 (LOCAL), one flit out, IDLE next.
REQ-036 HEAD dest (1,0), grant delayed 5 cycles -> out_valid stays 0 and req=01000 held 5 cycles.
REQ-037 Buffer empties after HEAD, BODY arrives 4 cycles later, out_ready toggling -> WAIT entered, no rd_en while empty, no flit lost or duplicated.
REQ-038 rst asserted in SEND mid-packet -> next cycle all outputs 0, state IDLE.
REQ-039 With INPUT_PORT_CHECK_EN, BODY flit from IDLE -> err pulse 1 cycle, out_valid never asserts, req stays 0.

Source files
------------

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - flit type codes, output port indices and input-port controller states
package noc_pkg;

  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  localparam int NUM_PORTS  = 5;
  localparam int PORT_LOCAL = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_EAST  = 2;
  localparam int PORT_SOUTH = 3;
  localparam int PORT_WEST  = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARB  = 3'd2,
    ST_SEND = 3'd3,
    ST_WAIT = 3'd4
  } ipc_state_t;

  function automatic logic is_head(input logic [1:0] ftype);
    return (ftype == FLIT_HEAD) || (ftype == FLIT_SINGLE);
  endfunction

  function automatic logic is_tail(input logic [1:0] ftype);
    return (ftype == FLIT_TAIL) || (ftype == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/xy_route_compute.sv
// rtl/xy_route_compute.sv - dimension-ordered (X then Y) route to a one-hot output port request
module xy_route_compute
  import noc_pkg::*;
#(
  parameter int COORD_WIDTH = 2,
  parameter int LOCAL_X     = 0,
  parameter int LOCAL_Y     = 0
) (
  input  logic [COORD_WIDTH-1:0] dest_x,
  input  logic [COORD_WIDTH-1:0] dest_y,
  output logic [NUM_PORTS-1:0]   req
);

  localparam logic [COORD_WIDTH-1:0] LX = COORD_WIDTH'(LOCAL_X);
  localparam logic [COORD_WIDTH-1:0] LY = COORD_WIDTH'(LOCAL_Y);

  always_comb begin
    req = '0;
    if (dest_x > LX)      req[PORT_EAST]  = 1'b1;
    else if (dest_x < LX) req[PORT_WEST]  = 1'b1;
    else if (dest_y > LY) req[PORT_NORTH] = 1'b1;
    else if (dest_y < LY) req[PORT_SOUTH] = 1'b1;
    else                  req[PORT_LOCAL] = 1'b1;
  end

endmodule

// File: rtl/input_port_ctrl.sv
// rtl/input_port_ctrl.sv - router input port: buffer pop, XY route, allocation request, flit send
// INPUT_PORT_CHECK_EN adds an err output and drops flits whose type breaks packet framing.
module input_port_ctrl
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int COORD_WIDTH = 2,
  parameter int LOCAL_X     = 0,
  parameter int LOCAL_Y     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic [NUM_PORTS-1:0]  req,
  input  logic                  grant,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef INPUT_PORT_CHECK_EN
  ,
  output logic                  err
`endif
);

  ipc_state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] flit_q, flit_d;
  logic [NUM_PORTS-1:0]  req_q, req_d, route_req;
  logic                  from_idle_q, from_idle_d;
  logic [1:0]            in_type;

  assign in_type = fifo_dout[DATA_WIDTH-1 -: 2];

  xy_route_compute #(
    .COORD_WIDTH(COORD_WIDTH),
    .LOCAL_X    (LOCAL_X),
    .LOCAL_Y    (LOCAL_Y)
  ) u_route (
    .dest_x(fifo_dout[DATA_WIDTH-3 -: COORD_WIDTH]),
    .dest_y(fifo_dout[DATA_WIDTH-3-COORD_WIDTH -: COORD_WIDTH]),
    .req   (route_req)
  );

  assign req      = req_q;
  assign out_data = flit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flit_q      <= '0;
      req_q       <= '0;
      from_idle_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flit_q      <= flit_d;
      req_q       <= req_d;
      from_idle_q <= from_idle_d;
    end
  end

  // from_idle marks that the flit being loaded opens a packet and must be routed.
  always_comb begin
    state_d     = state_q;
    flit_d      = flit_q;
    req_d       = req_q;
    from_idle_d = from_idle_q;
    fifo_rd_en  = 1'b0;
    out_valid   = 1'b0;
`ifdef INPUT_PORT_CHECK_EN
    err         = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        fifo_rd_en = ~fifo_empty;
        if (!fifo_empty) begin
          state_d     = ST_LOAD;
          from_idle_d = 1'b1;
        end
      end
      ST_LOAD: begin
        flit_d = fifo_dout;
`ifdef INPUT_PORT_CHECK_EN
        if (from_idle_q != is_head(in_type)) begin
          err     = 1'b1;
          req_d   = '0;
          state_d = ST_IDLE;
        end else
`endif
        if (from_idle_q) begin
          req_d   = route_req;
          state_d = ST_ARB;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_ARB: begin
        if (grant) state_d = ST_SEND;
      end
      ST_SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (is_tail(flit_q[DATA_WIDTH-1 -: 2])) begin
            req_d   = '0;
            state_d = ST_IDLE;
          end else begin
            from_idle_d = 1'b0;
            if (!fifo_empty) begin
              fifo_rd_en = 1'b1;
              state_d    = ST_LOAD;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        fifo_rd_en = ~fifo_empty;
        if (!fifo_empty) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_input_port_ctrl.sv
// tb/tb_input_port_ctrl.sv - scoreboard bench for input_port_ctrl with a behavioural buffer and route model
module tb_input_port_ctrl;
  localparam int DW = 32;
  localparam int CW = 2;
  localparam int LX = 1;
  localparam int LY = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout = '0;
  logic [4:0]    req;
  logic          grant = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
`ifdef INPUT_PORT_CHECK_EN
  logic          err;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic [4:0]    req;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] buf_q[$];
  logic [DW-1:0] pend_q[$];
  int n_tests = 0, n_fail = 0, accepted = 0;
  bit flush = 1'b0, rand_grant = 1'b0, rand_ready = 1'b0;

  always #5 clk = ~clk;

  input_port_ctrl #(.DATA_WIDTH(DW), .COORD_WIDTH(CW), .LOCAL_X(LX), .LOCAL_Y(LY)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_dout (fifo_dout),
    .req       (req),
    .grant     (grant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef INPUT_PORT_CHECK_EN
    ,
    .err       (err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: observed 0x%0h", name, act);
  endtask

  function automatic logic [4:0] ref_route(input int dx, input int dy);
    int dir;
    if (dx > LX)      dir = 2;
    else if (dx < LX) dir = 4;
    else if (dy > LY) dir = 1;
    else if (dy < LY) dir = 3;
    else              dir = 0;
    return 5'(1 << dir);
  endfunction

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input int dx, input int dy);
    logic [25:0] pl;
    pl = 26'($urandom);
    return {t, 2'(dx), 2'(dy), pl};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Input buffer model: registered read data, empty flag reflects pushes one edge later.
  always @(posedge clk) begin
    if (flush) begin
      buf_q.delete();
      pend_q.delete();
    end else begin
      if (fifo_rd_en) begin
        if (buf_q.size() == 0) flag("pop_underflow", 32'(fifo_rd_en));
        else fifo_dout <= buf_q.pop_front();
      end
      while (pend_q.size() > 0) buf_q.push_back(pend_q.pop_front());
    end
    fifo_empty <= (buf_q.size() == 0);
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    if (rand_grant) grant = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_rd_en && fifo_empty) flag("rd_en_while_empty", 32'(fifo_rd_en));
      if ((req & (req - 5'd1)) != 5'd0) flag("req_not_onehot", 32'(req));
      if (out_valid && req == 5'd0) flag("valid_without_req", 32'(req));
      if (out_valid && out_ready) begin
        accepted++;
        if (exp_q.size() == 0) flag("unexpected_flit", out_data);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("req_at_send", 32'(req), 32'(e.req));
        end
      end
    end
  end

  task automatic queue_packet(input int len, input int dx, input int dy, input int max_gap);
    logic [4:0]    r;
    logic [1:0]    t;
    logic [DW-1:0] f;
    r = ref_route(dx, dy);
    for (int i = 0; i < len; i++) begin
      if (len == 1)           t = 2'b11;
      else if (i == 0)        t = 2'b01;
      else if (i == len - 1)  t = 2'b10;
      else                    t = 2'b00;
      f = mk(t, dx, dy);
      exp_q.push_back('{f, r});
      pend_q.push_back(f);
      if (i < len - 1) repeat ($urandom_range(0, max_gap)) tick();
    end
  endtask

  task automatic drain(input int budget);
    while (exp_q.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int b;
    int target;
    logic [DW-1:0] f;

    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_req", 32'(req), 32'd0);
    chk("reset_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    tick();
    rst = 1'b0;
    grant = 1'b1;
    out_ready = 1'b1;

    // Three-flit packet east with immediate grant: pop N, req N+2, valid N+3.
    queue_packet(3, 3, 1, 0);
    tick();
    @(negedge clk); chk("lat_pop", 32'(fifo_rd_en), 32'd1);
    tick();
    @(negedge clk); chk("lat_load_no_valid", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk); chk("lat_req_east", 32'(req), 32'b00100);
    chk("lat_arb_no_valid", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk); chk("lat_valid", 32'(out_valid), 32'd1);
    drain(50);
    tick();
    @(negedge clk); chk("req_clear_after_tail", 32'(req), 32'd0);

    // Single flit to the local port.
    queue_packet(1, 1, 1, 0);
    drain(50);
    tick();
    @(negedge clk);
    chk("single_req_clear", 32'(req), 32'd0);
    chk("single_idle_no_valid", 32'(out_valid), 32'd0);

    // Delayed grant: request must hold with no flit presented.
    grant = 1'b0;
    queue_packet(2, 1, 0, 0);
    b = 0;
    while (req == 5'd0 && b < 20) begin tick(); b++; end
    chk("south_req_seen", 32'(req), 32'b01000);
    repeat (5) begin
      @(negedge clk);
      chk("grant_wait_req", 32'(req), 32'b01000);
      chk("grant_wait_no_valid", 32'(out_valid), 32'd0);
      tick();
    end
    grant = 1'b1;
    drain(50);

    // Buffer runs dry after the head; body arrives later with out_ready toggling.
    rand_ready = 1'b1;
    target = accepted + 1;
    f = mk(2'b01, 0, 1);
    exp_q.push_back('{f, ref_route(0, 1)});
    pend_q.push_back(f);
    b = 0;
    while (accepted < target && b < 60) begin tick(); b++; end
    chk("head_accepted", 32'(accepted), 32'(target));
    repeat (4) begin
      @(negedge clk);
      chk("wait_no_valid", 32'(out_valid), 32'd0);
      chk("wait_no_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("wait_req_held", 32'(req), 32'b10000);
      tick();
    end
    f = mk(2'b00, 0, 1);
    exp_q.push_back('{f, ref_route(0, 1)});
    pend_q.push_back(f);
    f = mk(2'b10, 0, 1);
    exp_q.push_back('{f, ref_route(0, 1)});
    pend_q.push_back(f);
    drain(100);
    rand_ready = 1'b0;
    tick();
    out_ready = 1'b1;

`ifdef INPUT_PORT_CHECK_EN
    begin : body_from_idle
      int errs, vals, reqs;
      errs = 0; vals = 0; reqs = 0;
      pend_q.push_back(mk(2'b00, 2, 2));
      repeat (8) begin
        tick();
        @(negedge clk);
        if (err) errs++;
        if (out_valid) vals++;
        if (req != 5'd0) reqs++;
      end
      chk("err_pulse_count", 32'(errs), 32'd1);
      chk("err_no_valid", 32'(vals), 32'd0);
      chk("err_no_req", 32'(reqs), 32'd0);
    end
`endif

    // Reset while presenting the head of a multi-flit packet.
    out_ready = 1'b0;
    queue_packet(3, 2, 2, 0);
    b = 0;
    while (!out_valid && b < 20) begin tick(); b++; end
    chk("send_reached", 32'(out_valid), 32'd1);
    rst = 1'b1;
    flush = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_req", 32'(req), 32'd0);
    chk("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    tick();
    out_ready = 1'b1;

    // Randomized traffic with random grant and backpressure.
    rand_grant = 1'b1;
    rand_ready = 1'b1;
    repeat (30) begin
      queue_packet($urandom_range(1, 5), $urandom_range(0, 3), $urandom_range(0, 3), 2);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain(3000);
    rand_grant = 1'b0;
    rand_ready = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    flag("global_timeout", 32'(exp_q.size()));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
